// File: rtl/itof_pipe.sv
// itof_pipe -- three-stage signed 32-bit integer to IEEE-754 single converter.
//
// Takes a two's-complement integer from the integer register read port and
// produces a single-precision value for FP register writeback. The result
// also feeds int->float->int round trips through the float-to-int stage.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous active-high reset
//   in_valid   input beat present
//   in_ready   block can take an input beat this cycle
//   x          signed integer operand
//   rm         rounding: 0 = toward zero, 1 = nearest with ties away from zero
//   out_valid  result present
//   out_ready  consumer accepts the result this cycle
//   y          single-precision result {sign, exp[7:0], mant[22:0]}
//   inexact    (ITOF_INEXACT_EN only) result lost nonzero bits before rounding
//
// Build option:
//   ITOF_INEXACT_EN  adds the inexact output, registered alongside y.
//
// Pipeline:
//   S1 captures sign and magnitude, S2 normalises, S3 rounds and packs.
//   The stall is global: every stage holds together when the output is
//   presented and not taken, so bubbles are not squeezed out.

module itof_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x,
    input  logic        rm,
    output logic        out_valid,
    input  logic        out_ready,
`ifdef ITOF_INEXACT_EN
    output logic        inexact,
`endif
    output logic [31:0] y
);

    // Lowest normalised bit kept in S2. The sticky bits norm[6:0] only
    // matter for the inexact flag, so they are dropped when it is absent.
`ifdef ITOF_INEXACT_EN
    localparam int NormLsb = 0;
`else
    localparam int NormLsb = 7;
`endif
    localparam int NormW = 31 - NormLsb;

    logic                adv;

    logic                v1_q, v2_q, v3_q;

    logic                s1Sign_q;
    logic                s1Rm_q;
    logic [31:0]         s1Mag_q;
    logic [31:0]         s1Mag_d;

    logic [4:0]          lz_d;
    logic [7:0]          s2Exp_d;
    logic [30:NormLsb]   s2Norm_d;
    logic                s2Zero_d;

    logic                s2Sign_q;
    logic                s2Rm_q;
    logic                s2Zero_q;
    logic [7:0]          s2Exp_q;
    logic [30:NormLsb]   s2Norm_q;

    logic [23:0]         mantSum;
    logic [7:0]          expFinal;
    logic [31:0]         y_d;
    logic [31:0]         y_q;

    // One global advance: everything moves unless a result is being held.
    assign adv       = !v3_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = v3_q;
    assign y         = y_q;

    // Magnitude of the operand; 0x80000000 negates to itself, which is the
    // correct unsigned magnitude 2^31.
    always_comb begin
        s1Mag_d = x[31] ? (~x + 32'd1) : x;
    end

    // Leading-zero count by scanning upward so the highest set bit wins.
    // A zero magnitude leaves lz at 31; the zero flag overrides the result.
    always_comb begin
        lz_d = 5'd31;
        for (int i = 0; i < 32; i++) begin
            if (s1Mag_q[i]) begin
                lz_d = 5'(31 - i);
            end
        end
    end

    // Normalise so the leading one sits at bit 31 (implicit, not stored),
    // and derive the biased exponent: 127 + (31 - lz).
    always_comb begin
        s2Norm_d = NormW'((s1Mag_q << lz_d) >> NormLsb);
        s2Exp_d  = 8'd158 - {3'd0, lz_d};
        s2Zero_d = (s1Mag_q == 32'd0);
    end

    // Round and pack. Only the guard bit decides rounding because ties go
    // away from zero. A carry out of an all-ones mantissa leaves the low 23
    // bits zero and bumps the exponent; the exponent cannot exceed 158.
    always_comb begin
        mantSum  = {1'b0, s2Norm_q[30:8]} + {23'd0, (s2Rm_q & s2Norm_q[7])};
        expFinal = s2Exp_q + {7'd0, mantSum[23]};
        y_d      = s2Zero_q ? 32'd0 : {s2Sign_q, expFinal, mantSum[22:0]};
    end

    // Valid bits and the output register are the only reset state. y only
    // reloads when a real beat enters S3, so it stays quiet across bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            y_q  <= 32'd0;
        end else if (adv) begin
            v1_q <= in_valid;
            v2_q <= v1_q;
            v3_q <= v2_q;
            if (v2_q) begin
                y_q <= y_d;
            end
        end
    end

    // Datapath stage registers; no reset needed since the valid bits
    // qualify them.
    always_ff @(posedge clk) begin
        if (adv) begin
            s1Sign_q <= x[31];
            s1Rm_q   <= rm;
            s1Mag_q  <= s1Mag_d;
            s2Sign_q <= s1Sign_q;
            s2Rm_q   <= s1Rm_q;
            s2Zero_q <= s2Zero_d;
            s2Exp_q  <= s2Exp_d;
            s2Norm_q <= s2Norm_d;
        end
    end

`ifdef ITOF_INEXACT_EN
    logic inexact_d;
    logic inexact_q;

    // Inexact reflects bits discarded before rounding: guard or sticky.
    always_comb begin
        inexact_d = !s2Zero_q && (s2Norm_q[7] || (|s2Norm_q[6:0]));
    end

    // Registered with y so the flag always describes the presented result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inexact_q <= 1'b0;
        end else if (adv && v2_q) begin
            inexact_q <= inexact_d;
        end
    end

    assign inexact = inexact_q;
`endif

endmodule
